// File: rtl/inst_fetch_unit.sv
// Instruction fetch front end: reads a byte-wide instruction memory one byte
// per handshake (big-endian), assembles 32-bit words, buffers them with their
// PC in a small FIFO and hands them to decode over a valid/ready interface.
// A redirect flushes every in-flight and buffered fetch.
module inst_fetch_unit #(
    parameter int          ADDR_W     = 5,
    parameter int          FIFO_DEPTH = 2,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [7:0]        imem_rdata,
    input  logic              redirect,
    input  logic [31:0]       redirect_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [31:0]       inst,
    output logic [31:0]       inst_pc
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        STALL
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [31:0]       fetch_pc;
    logic [1:0]        byte_cnt;
    logic [23:0]       asm_bytes;
    logic [31:0]       fifo_word [FIFO_DEPTH];
    logic [31:0]       fifo_pc   [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;
    logic [31:0]       last_word;
    logic [31:0]       last_pc;
    logic              full;
    logic              xfer;
    logic              push;
    logic              pop;
    logic              unused_pc_bits;

    // The low two redirect bits are dropped because fetch is always word aligned
    assign unused_pc_bits = ^redirect_pc[1:0];

    assign full       = (count == FULL_CNT);
    assign imem_req   = (state == FETCH) && !full;
    assign imem_addr  = (state == IDLE) ? '0 : fetch_pc[ADDR_W-1:0] + ADDR_W'(byte_cnt);
    assign xfer       = imem_req && imem_ack && !redirect;
    assign push       = xfer && (byte_cnt == 2'd3);
    assign inst_valid = (count != '0);
    assign pop        = inst_valid && inst_ready;
    assign inst       = inst_valid ? fifo_word[rd_ptr] : last_word;
    assign inst_pc    = inst_valid ? fifo_pc[rd_ptr]   : last_pc;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: stall while the FIFO is full and nothing drains it; redirect restarts fetch
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = FETCH;
            FETCH:   if (full && !pop) state_next = STALL;
            STALL:   if (!full || pop) state_next = FETCH;
            default: state_next = IDLE;
        endcase
        if (redirect) begin
            state_next = FETCH;
        end
    end

    // Fetch PC, byte counter and partial-word assembly; redirect discards the partial word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc  <= RESET_PC;
            byte_cnt  <= 2'd0;
            asm_bytes <= 24'h0;
        end else if (redirect) begin
            fetch_pc <= {redirect_pc[31:2], 2'b00};
            byte_cnt <= 2'd0;
        end else if (xfer) begin
            asm_bytes <= {asm_bytes[15:0], imem_rdata};
            byte_cnt  <= byte_cnt + 2'd1;
            if (push) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
        end
    end

    // FIFO pointers and occupancy; a flush empties it regardless of push or pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (redirect) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // FIFO storage, written with the completed word and the PC it was fetched from
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_word[i] <= 32'h0;
                fifo_pc[i]   <= 32'h0;
            end
        end else if (push && !redirect) begin
            fifo_word[wr_ptr] <= {asm_bytes, imem_rdata};
            fifo_pc[wr_ptr]   <= fetch_pc;
        end
    end

    // Remember the last consumed entry so inst/inst_pc hold steady once the FIFO empties
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_word <= 32'h0;
            last_pc   <= 32'h0;
        end else if (pop) begin
            last_word <= fifo_word[rd_ptr];
            last_pc   <= fifo_pc[rd_ptr];
        end
    end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Testbench for inst_fetch_unit: directed phases plus randomized traffic, with a
// scoreboard fed from a word-level model of the instruction memory.
module tb_inst_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [4:0]  imem_addr;
    logic        imem_ack;
    logic [7:0]  imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;

    typedef struct packed {
        logic [31:0] word;
        logic [31:0] pc;
    } exp_t;

    logic [7:0]  mem [32];
    exp_t        exp_q [$];
    int          test_count;
    int          fail_count;
    int          ack_mode;
    int          ack_cyc;
    logic        prev_req;
    logic        prev_ack;
    logic        prev_redir;
    logic [4:0]  prev_addr;

    inst_fetch_unit #(
        .ADDR_W     (5),
        .FIFO_DEPTH (2),
        .RESET_PC   (32'd28)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .inst        (inst),
        .inst_pc     (inst_pc)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        test_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // A word is four consecutive memory bytes, most significant first, addresses wrap at 32
    function automatic logic [31:0] modelWord(input logic [31:0] pc);
        logic [4:0] a0, a1, a2, a3;
        a0 = pc[4:0];
        a1 = a0 + 5'd1;
        a2 = a0 + 5'd2;
        a3 = a0 + 5'd3;
        return {mem[a0], mem[a1], mem[a2], mem[a3]};
    endfunction

    // Expected instruction stream from a fresh start PC
    task automatic loadStream(input logic [31:0] start);
        logic [31:0] pc;
        exp_t e;
        exp_q.delete();
        pc = {start[31:2], 2'b00};
        for (int i = 0; i < 128; i++) begin
            e.word = modelWord(pc);
            e.pc   = pc;
            exp_q.push_back(e);
            pc = pc + 32'd4;
        end
    endtask

    // Pulse a redirect, rebuild the expected stream, then confirm the FIFO flushed
    task automatic applyStimulus(input logic [31:0] pc);
        @(posedge clk);
        #1;
        redirect    = 1'b1;
        redirect_pc = pc;
        @(posedge clk);
        #1;
        redirect = 1'b0;
        loadStream(pc);
        @(negedge clk);
        checkOutput("flush_valid", 32'(inst_valid), 32'd0);
    endtask

    // Memory responder: ack pattern selected by ack_mode, data looked up combinationally
    always @(posedge clk) begin
        #1;
        ack_cyc = ack_cyc + 1;
        case (ack_mode)
            0:       imem_ack = 1'b1;
            1:       imem_ack = (ack_cyc % 3 == 0);
            default: imem_ack = 1'($urandom_range(0, 1));
        endcase
        imem_rdata = mem[imem_addr];
    end

    // Monitor: score every consumed instruction and check address stability while unacked
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prev_req   = 1'b0;
            prev_ack   = 1'b0;
            prev_redir = 1'b0;
            prev_addr  = '0;
        end else begin
            if (inst_valid && inst_ready) begin
                if (exp_q.size() == 0) begin
                    test_count++;
                    fail_count++;
                    $display("[TB] FAIL scoreboard_underflow: got pc %h, expected no output", inst_pc);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("inst_word", inst, e.word);
                    checkOutput("inst_pc", inst_pc, e.pc);
                end
            end
            if (prev_req && !prev_ack && !prev_redir && imem_req) begin
                checkOutput("addr_stable", 32'(imem_addr), 32'(prev_addr));
            end
            prev_req   = imem_req;
            prev_ack   = imem_ack;
            prev_redir = redirect;
            prev_addr  = imem_addr;
        end
    end

    // Directed phases followed by randomized traffic
    initial begin
        logic        pending;
        logic [31:0] pend_pc;
        logic [31:0] base;
        test_count  = 0;
        fail_count  = 0;
        ack_cyc     = 0;
        ack_mode    = 0;
        imem_ack    = 1'b0;
        imem_rdata  = 8'h0;
        rst_n       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        inst_ready  = 1'b1;
        pending     = 1'b0;
        pend_pc     = 32'h0;
        for (int i = 0; i < 32; i++) mem[i] = 8'($urandom);
        mem[0] = 8'h8C; mem[1] = 8'h04; mem[2] = 8'h00; mem[3] = 8'h00;
        mem[4] = 8'hAC; mem[5] = 8'h05; mem[6] = 8'h00; mem[7] = 8'h04;
        loadStream(32'd28);

        repeat (2) @(negedge clk);
        checkOutput("rst_req", 32'(imem_req), 32'd0);
        checkOutput("rst_addr", 32'(imem_addr), 32'd0);
        checkOutput("rst_valid", 32'(inst_valid), 32'd0);
        checkOutput("rst_inst", inst, 32'd0);
        checkOutput("rst_inst_pc", inst_pc, 32'd0);

        // Startup timing and address wrap from PC 28
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int c = 0; c <= 5; c++) begin
            @(negedge clk);
            checkOutput("start_req", 32'(imem_req), 32'(c >= 1));
            checkOutput("start_valid", 32'(inst_valid), 32'(c == 5));
            if (c >= 1) checkOutput("start_addr", 32'(imem_addr), (32'd28 + 32'(c - 1)) % 32);
        end
        repeat (8) @(posedge clk);

        // Sequential fetch from 0, then a redirect to 0xA two bytes into a word
        applyStimulus(32'h0);
        repeat (12) @(posedge clk);
        applyStimulus(32'h0);
        @(posedge clk);
        applyStimulus(32'h0000_000A);
        checkOutput("redir_addr", 32'(imem_addr), 32'd8);
        for (int k = 1; k < 4; k++) begin
            @(negedge clk);
            checkOutput("redir_addr", 32'(imem_addr), 32'd8 + 32'(k));
        end
        repeat (6) @(posedge clk);

        // Backpressure: fill the FIFO, release exactly one entry, then drain
        @(posedge clk);
        #1 inst_ready = 1'b0;
        base = 32'h10;
        applyStimulus(base);
        repeat (10) @(negedge clk);
        checkOutput("bp_req", 32'(imem_req), 32'd0);
        checkOutput("bp_valid", 32'(inst_valid), 32'd1);
        checkOutput("bp_addr", 32'(imem_addr), (base + 32'd8) % 32);
        repeat (3) @(negedge clk);
        checkOutput("bp_req_hold", 32'(imem_req), 32'd0);
        checkOutput("bp_addr_hold", 32'(imem_addr), (base + 32'd8) % 32);
        @(posedge clk);
        #1 inst_ready = 1'b1;
        @(posedge clk);
        #1 inst_ready = 1'b0;
        @(negedge clk);
        checkOutput("bp_resume_req", 32'(imem_req), 32'd1);
        repeat (12) @(posedge clk);
        #1 inst_ready = 1'b1;
        repeat (20) @(posedge clk);

        // Slow memory: ack every third cycle
        ack_mode = 1;
        applyStimulus(32'h0);
        repeat (60) @(posedge clk);
        ack_mode = 0;

        // Asynchronous reset mid-word with one buffered entry
        @(posedge clk);
        #1 inst_ready = 1'b0;
        applyStimulus(32'h0);
        repeat (5) @(negedge clk);
        checkOutput("pre_reset_valid", 32'(inst_valid), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("async_req", 32'(imem_req), 32'd0);
        checkOutput("async_valid", 32'(inst_valid), 32'd0);
        checkOutput("async_inst", inst, 32'd0);
        loadStream(32'd28);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n      = 1'b1;
        inst_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checkOutput("restart_req", 32'(imem_req), 32'd1);
        checkOutput("restart_addr", 32'(imem_addr), 32'd28);
        repeat (10) @(posedge clk);

        // Randomized ready, ack and redirects
        ack_mode = 2;
        for (int i = 0; i < 600; i++) begin
            @(posedge clk);
            #1;
            if (pending) begin
                redirect = 1'b0;
                loadStream(pend_pc);
                pending = 1'b0;
            end
            inst_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 39) == 0) begin
                redirect    = 1'b1;
                redirect_pc = $urandom;
                pend_pc     = redirect_pc;
                pending     = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        if (pending) begin
            redirect = 1'b0;
            loadStream(pend_pc);
        end
        repeat (10) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

endmodule
